// File: rtl/leaf_out_arb_pkg.sv
// ============================================================================
// Module      : leaf_out_arb_pkg
// Description : Shared types, packet field offsets and the packet builder
//               for leaf_out_arbiter. The field widths here define the
//               packet format; instance parameters must match them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package leaf_out_arb_pkg;

  localparam int C_PAYLOAD_W = 32;
  localparam int C_LEAF_W    = 5;
  localparam int C_PORT_W    = 4;
  localparam int C_ADDR_W    = 7;
  localparam int C_PKT_W     = 1 + C_LEAF_W + C_PORT_W + C_ADDR_W + C_PAYLOAD_W;

  // Packet layout, LSB first: payload, addr, port, leaf, valid flag on top.
  localparam int C_PAYLOAD_LSB = 0;
  localparam int C_ADDR_LSB    = C_PAYLOAD_LSB + C_PAYLOAD_W;
  localparam int C_PORT_LSB    = C_ADDR_LSB + C_ADDR_W;
  localparam int C_LEAF_LSB    = C_PORT_LSB + C_PORT_W;
  localparam int C_VALID_BIT   = C_LEAF_LSB + C_LEAF_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_t;

  function automatic logic [C_PKT_W-1:0] pack(
    input logic [C_LEAF_W-1:0]    leaf,
    input logic [C_PORT_W-1:0]    port,
    input logic [C_ADDR_W-1:0]    addr,
    input logic [C_PAYLOAD_W-1:0] payload
  );
    logic [C_PKT_W-1:0] p;
    p = '0;
    p[C_VALID_BIT]                     = 1'b1;
    p[C_LEAF_LSB    +: C_LEAF_W]       = leaf;
    p[C_PORT_LSB    +: C_PORT_W]       = port;
    p[C_ADDR_LSB    +: C_ADDR_W]       = addr;
    p[C_PAYLOAD_LSB +: C_PAYLOAD_W]    = payload;
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Returns the first active
//               request at or after the pointer, wrapping cyclically.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan from the pointer forward; the first hit wins.
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/leaf_out_arbiter.sv
// ============================================================================
// Module      : leaf_out_arbiter
// Description : Round-robin merge of user output streams onto the single
//               leaf-to-BFT packet path, with per-stream credit tracking and
//               rolling destination BRAM addresses.
//               Optional macro LEAF_OUT_ARB_STATS_EN adds grant/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leaf_out_arbiter
  import leaf_out_arb_pkg::*;
#(
  parameter int PACKET_BITS           = C_PKT_W,
  parameter int PAYLOAD_BITS          = C_PAYLOAD_W,
  parameter int NUM_LEAF_BITS         = C_LEAF_W,
  parameter int NUM_PORT_BITS         = C_PORT_W,
  parameter int NUM_ADDR_BITS         = C_ADDR_W,
  parameter int NUM_OUT_PORTS         = 4,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  ap_rst_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  input  logic                                  cfg_wr_en,
  input  logic [3:0]                            cfg_idx,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic                                  credit_upd,
  input  logic [3:0]                            credit_idx,
  output logic [PACKET_BITS-1:0]                pkt_out,
  output logic                                  pkt_vld,
  input  logic                                  pkt_rdy
`ifdef LEAF_OUT_ARB_STATS_EN
  ,
  input  logic [3:0]                            stat_sel,
  output logic [31:0]                           stat_grant_cnt,
  output logic [31:0]                           stat_stall_cnt
`endif
);

  localparam int C_IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int C_CRD_W = NUM_ADDR_BITS + 1;
  localparam logic [C_CRD_W-1:0] C_CRD_MAX = C_CRD_W'(1 << NUM_ADDR_BITS);
  localparam logic [C_CRD_W:0]   C_CRD_MAX_X = {1'b0, C_CRD_MAX};
  localparam logic [C_CRD_W:0]   C_UPD = (C_CRD_W+1)'(FREESPACE_UPDATE_SIZE);

  arb_state_t                r_state;
  logic [C_IDX_W-1:0]        r_ptr;
  logic [C_IDX_W-1:0]        r_grant;
  logic [C_CRD_W-1:0]        r_credit [NUM_OUT_PORTS];
  logic [C_CRD_W-1:0]        w_credit_nxt [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]  r_addr [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]  r_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]  r_port [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0]  r_cfg_valid;

  logic [NUM_OUT_PORTS-1:0]  w_req;
  logic [NUM_OUT_PORTS-1:0]  w_gnt;
  logic [C_IDX_W-1:0]        w_gnt_idx;
  logic                      w_any;
  logic                      w_grant_fire;
  logic [PAYLOAD_BITS-1:0]   w_payload;

  // A stream may compete only when valid, configured and holding credit.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_req[i] = vld_user[i] & r_cfg_valid[i] & (r_credit[i] != '0);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_OUT_PORTS),
    .IDX_W   (C_IDX_W)
  ) u_rr_arbiter (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  assign w_grant_fire = (r_state == ST_IDLE) && w_any;
  assign ack_user     = w_grant_fire ? w_gnt : '0;
  assign w_payload    = din_user[int'(w_gnt_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];

  // Arbitration FSM: latch the packet on grant, hold it until accepted.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      pkt_out <= '0;
      pkt_vld <= 1'b0;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            pkt_out <= pack(r_leaf[w_gnt_idx], r_port[w_gnt_idx],
                            r_addr[w_gnt_idx], w_payload);
            pkt_vld <= 1'b1;
            r_grant <= w_gnt_idx;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pkt_rdy) begin
            pkt_vld <= 1'b0;
            r_ptr   <= (r_grant == C_IDX_W'(NUM_OUT_PORTS-1)) ? '0 : r_grant + 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Next credit: +update, -grant, saturated at full BRAM depth.
  always_comb begin
    logic [C_CRD_W:0] v_sum;
    v_sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      v_sum = {1'b0, r_credit[i]}
            + ((credit_upd && (credit_idx == 4'(i))) ? C_UPD : '0)
            - ((w_grant_fire && w_gnt[i]) ? (C_CRD_W+1)'(1) : '0);
      w_credit_nxt[i] = (v_sum > C_CRD_MAX_X) ? C_CRD_MAX : v_sum[C_CRD_W-1:0];
    end
  end

  // Credit and rolling address per stream.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_credit[i] <= C_CRD_MAX;
        r_addr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_credit[i] <= w_credit_nxt[i];
        if (w_grant_fire && w_gnt[i]) begin
          r_addr[i] <= r_addr[i] + 1'b1;
        end
      end
    end
  end

  // Destination table; out-of-range indices match no entry.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cfg_valid <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_leaf[i] <= '0;
        r_port[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_idx == 4'(i)) begin
          r_leaf[i]      <= cfg_leaf;
          r_port[i]      <= cfg_port;
          r_cfg_valid[i] <= 1'b1;
        end
      end
    end
  end

`ifdef LEAF_OUT_ARB_STATS_EN
  logic [31:0] r_grant_cnt [NUM_OUT_PORTS];
  logic [31:0] r_stall_cnt;

  // Free-running grant and backpressure counters.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_stall_cnt <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_grant_cnt[i] <= '0;
      end
    end else begin
      if (pkt_vld && !pkt_rdy) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (w_grant_fire && w_gnt[i]) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign stat_grant_cnt = (int'(stat_sel) < NUM_OUT_PORTS)
                        ? r_grant_cnt[stat_sel[C_IDX_W-1:0]] : '0;
  assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_leaf_out_arbiter.sv
// ============================================================================
// Module      : tb_leaf_out_arbiter
// Description : Directed, scoreboard-based bench for leaf_out_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leaf_out_arbiter;

  logic         clk;
  logic         ap_rst_n;
  logic [127:0] din_user;
  logic [3:0]   vld_user;
  logic [3:0]   ack_user;
  logic         cfg_wr_en;
  logic [3:0]   cfg_idx;
  logic [4:0]   cfg_leaf;
  logic [3:0]   cfg_port;
  logic         credit_upd;
  logic [3:0]   credit_idx;
  logic [48:0]  pkt_out;
  logic         pkt_vld;
  logic         pkt_rdy;

  leaf_out_arbiter dut (
    .clk        (clk),
    .ap_rst_n   (ap_rst_n),
    .din_user   (din_user),
    .vld_user   (vld_user),
    .ack_user   (ack_user),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_idx    (cfg_idx),
    .cfg_leaf   (cfg_leaf),
    .cfg_port   (cfg_port),
    .credit_upd (credit_upd),
    .credit_idx (credit_idx),
    .pkt_out    (pkt_out),
    .pkt_vld    (pkt_vld),
    .pkt_rdy    (pkt_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [48:0] sb [$];
  logic [31:0] src_q [4][$];
  int          acc_cyc [$];
  logic [6:0]  m_addr [4];
  logic [4:0]  m_leaf [4];
  logic [3:0]  m_port [4];
  logic [3:0]  ack_s;
  logic [48:0] bp_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic src_push(input int i, input logic [31:0] d);
    src_q[i].push_back(d);
  endtask

  task automatic exp_pkt(input int i, input logic [31:0] d);
    sb.push_back(mk(m_leaf[i], m_port[i], m_addr[i], d));
    m_addr[i] = m_addr[i] + 7'd1;
  endtask

  task automatic send(input int i, input logic [31:0] d);
    src_push(i, d);
    exp_pkt(i, d);
  endtask

  task automatic cfg(input int i, input logic [4:0] l, input logic [3:0] p);
    step();
    cfg_wr_en = 1'b1; cfg_idx = 4'(i); cfg_leaf = l; cfg_port = p;
    m_leaf[i] = l; m_port[i] = p;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic upd(input int i);
    step();
    credit_upd = 1'b1; credit_idx = 4'(i);
    step();
    credit_upd = 1'b0;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Sends n words expected to go out, then 2 that must stay unacked.
  task automatic drain_check(input int i, input int n, input logic [31:0] base, input string tag);
    for (int k = 0; k < n; k++) send(i, base + 32'(k));
    src_push(i, 32'hFFFF_0000);
    src_push(i, 32'hFFFF_0001);
    wait_sb({tag, "_drain"}, 2*n + 40);
    repeat (10) @(negedge clk);
    chk({tag, "_left"}, 64'(src_q[i].size()), 64'd2);
  endtask

  // Stream sources: ack sampled mid-cycle, queue advanced just after the edge.
  initial begin
    vld_user = '0;
    din_user = '0;
    forever begin
      @(negedge clk);
      ack_s = ack_user;
      chk("ack_onehot0", 64'($onehot0(ack_user)), 64'd1);
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (ack_s[i]) begin
          checks++;
          assert (src_q[i].size() != 0) else begin
            errors++;
            $error("FAIL ack_without_vld stream=%0d observed=ack expected=no_ack", i);
          end
          if (src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        vld_user[i] = (src_q[i].size() != 0);
        din_user[i*32 +: 32] = (src_q[i].size() != 0) ? src_q[i][0] : 32'd0;
      end
    end
  end

  // Packet monitor: compare every accepted packet with the scoreboard head.
  always @(negedge clk) begin
    if (ap_rst_n && pkt_vld && pkt_rdy) begin
      acc_cyc.push_back(cyc);
      if (sb.size() != 0) begin
        chk("pkt", 64'(pkt_out), 64'(sb.pop_front()));
      end else begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pkt observed=%h expected=none", pkt_out);
        end
      end
    end
  end

  initial begin
    int n;
    ap_rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_idx = '0; cfg_leaf = '0; cfg_port = '0;
    credit_upd = 1'b0; credit_idx = '0; pkt_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin m_addr[i] = '0; m_leaf[i] = '0; m_port[i] = '0; end

    // Reset state
    @(negedge clk);
    chk("rst_vld", 64'(pkt_vld), 64'd0);
    chk("rst_pkt", 64'(pkt_out), 64'd0);
    chk("rst_ack", 64'(ack_user), 64'd0);
    @(posedge clk); #1 ap_rst_n = 1'b1;

    // Single stream, 1-cycle latency, fixed packet image
    cfg(0, 5'd3, 4'd2);
    step();
    pkt_rdy = 1'b1;
    send(0, 32'hDEADBEEF);
    @(negedge clk);
    chk("ss_ack", 64'(ack_user), 64'h1);
    @(negedge clk);
    chk("ss_vld", 64'(pkt_vld), 64'd1);
    chk("ss_pkt", 64'(pkt_out), 64'h1_1900_DEAD_BEEF);
    chk("ss_ack_once", 64'(ack_user), 64'h0);
    wait_sb("ss_done", 20);

    // Credit exhaustion on stream 1
    cfg(1, 5'd7, 4'd5);
    step();
    drain_check(1, 128, 32'h1100_0000, "exh");
    chk("exh_addr_wrap", 64'(m_addr[1]), 64'd0);
    exp_pkt(1, 32'hFFFF_0000);
    exp_pkt(1, 32'hFFFF_0001);
    for (int k = 0; k < 62; k++) send(1, 32'h1200_0000 + 32'(k));
    src_push(1, 32'hEEEE_0000);
    src_push(1, 32'hEEEE_0001);
    upd(1);
    wait_sb("upd_drain", 200);
    repeat (10) @(negedge clk);
    chk("upd_left", 64'(src_q[1].size()), 64'd2);

    // Stream with zero credit is skipped, others proceed
    cfg(3, 5'd31, 4'd15);
    step();
    send(3, 32'h3333_0001);
    wait_sb("skip_other", 20);
    chk("skip_left", 64'(src_q[1].size()), 64'd2);
    step();
    src_q[1].delete();
    upd(1);

    // Round robin, one packet every 2 cycles
    cfg(2, 5'd9, 4'd1);
    step();
    acc_cyc.delete();
    send(0, 32'hA000_0000);
    send(1, 32'hA100_0000);
    send(2, 32'hA200_0000);
    send(3, 32'hA300_0000);
    send(0, 32'hA000_0001);
    wait_sb("rr_drain", 40);
    chk("rr_count", 64'(acc_cyc.size()), 64'd5);
    for (int k = 0; k < 4; k++) begin
      if (k + 1 < acc_cyc.size()) chk("rr_gap", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'd2);
    end

    // Backpressure: packet held stable, no acks
    step();
    pkt_rdy = 1'b0;
    bp_exp = mk(m_leaf[1], m_port[1], m_addr[1], 32'hB100_0000);
    send(1, 32'hB100_0000);
    send(2, 32'hB200_0000);
    @(negedge clk);
    chk("bp_grant", 64'(ack_user), 64'h2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_vld", 64'(pkt_vld), 64'd1);
      chk("bp_stable", 64'(pkt_out), 64'(bp_exp));
      chk("bp_no_ack", 64'(ack_user), 64'h0);
    end
    step();
    pkt_rdy = 1'b1;
    wait_sb("bp_drain", 20);

    // Grant plus update on the same stream: 10 -> 73
    for (int k = 0; k < 116; k++) send(2, 32'hC000_0000 + 32'(k));
    wait_sb("sim_pre", 300);
    step();
    send(2, 32'hC100_0000);
    credit_upd = 1'b1; credit_idx = 4'd2;
    @(negedge clk);
    chk("sim_ack", 64'(ack_user), 64'h4);
    step();
    credit_upd = 1'b0;
    drain_check(2, 73, 32'hC200_0000, "sim73");
    step();
    src_q[2].delete();

    // Same with full credit: stays saturated at 128
    upd(2);
    upd(2);
    step();
    send(2, 32'hC300_0000);
    credit_upd = 1'b1; credit_idx = 4'd2;
    @(negedge clk);
    chk("sat_ack", 64'(ack_user), 64'h4);
    step();
    credit_upd = 1'b0;
    drain_check(2, 128, 32'hC400_0000, "sat128");
    step();
    src_q[2].delete();

    // Reset during SEND
    step();
    pkt_rdy = 1'b0;
    src_push(3, 32'hD000_0000);
    n = 0;
    while (!pkt_vld && n < 10) begin @(negedge clk); n++; end
    chk("rst_pre_vld", 64'(pkt_vld), 64'd1);
    @(posedge clk);
    #3 ap_rst_n = 1'b0;
    #1;
    chk("rst_async_vld", 64'(pkt_vld), 64'd0);
    chk("rst_async_pkt", 64'(pkt_out), 64'd0);
    for (int i = 0; i < 4; i++) begin src_q[i].delete(); m_addr[i] = '0; end
    repeat (2) @(posedge clk);
    #1 ap_rst_n = 1'b1;
    pkt_rdy = 1'b1;
    step();
    src_push(0, 32'h5555_AAAA);
    step();
    cfg_wr_en = 1'b1; cfg_idx = 4'd4; cfg_leaf = 5'd3; cfg_port = 4'd2;
    step();
    cfg_wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_cfg_cleared", 64'({ack_user, pkt_vld}), 64'd0);
    end
    cfg(0, 5'd3, 4'd2);
    exp_pkt(0, 32'h5555_AAAA);
    wait_sb("rst_addr0", 20);
    cfg(1, 5'd7, 4'd5);
    step();
    drain_check(1, 128, 32'hE000_0000, "rst_credit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Shares the single leaf-to-BFT injection path among NUM_OUT_PORTS user output streams, which arrive as TDATA/TVALID/TREADY-style triples from the user kernel.
- Round-robin arbitration with per-stream credit (freespace) tracking against the receiving leaf's input BRAM.
- Each granted word is wrapped into a PACKET_BITS packet carrying destination leaf, destination port and a rolling BRAM address.
- Sits between the user kernel outputs and the packet-out side of the leaf interface.

Parameters:
PACKET_BITS, 49, packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
PAYLOAD_BITS, 32, user data width
NUM_LEAF_BITS, 5, destination leaf field width
NUM_PORT_BITS, 4, destination port field width
NUM_ADDR_BITS, 7, destination BRAM address width; credit depth is 2^NUM_ADDR_BITS
NUM_OUT_PORTS, 4, number of user output streams (1..16)
FREESPACE_UPDATE_SIZE, 64, credits returned per update pulse

Ports:
clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
din_user  in  NUM_OUT_PORTS*PAYLOAD_BITS  stream payloads, stream i at slice i
vld_user  in  NUM_OUT_PORTS  per-stream valid
ack_user  out  NUM_OUT_PORTS  per-stream ready; one-hot or zero
cfg_wr_en  in  1  destination config write strobe
cfg_idx  in  4  stream index to configure
cfg_leaf  in  NUM_LEAF_BITS  destination leaf
cfg_port  in  NUM_PORT_BITS  destination port
credit_upd  in  1  freespace update pulse
credit_idx  in  4  stream receiving the update
pkt_out  out  PACKET_BITS  packet to BFT
pkt_vld  out  1  packet valid
pkt_rdy  in  1  BFT accepts packet

Behaviour:
- Reset (async assert, sync release): ack_user=0, pkt_out=0, pkt_vld=0, rr pointer=0, every credit=2^NUM_ADDR_BITS, every addr=0, every cfg_valid=0, state=IDLE.
- Packet format: [PACKET_BITS-1] valid=1; next NUM_LEAF_BITS dest leaf; next NUM_PORT_BITS dest port; next NUM_ADDR_BITS addr; low PAYLOAD_BITS payload.
- Eligibility of stream i: vld_user[i] & cfg_valid[i] & credit[i]!=0.
- FSM IDLE: if any stream is eligible, grant the first eligible index at or after rr pointer, cyclic. In that cycle assert ack_user[grant] combinationally and latch the packet into the output register, then go to SEND. Otherwise stay in IDLE.
- FSM SEND: hold pkt_vld=1 with pkt_out stable until pkt_rdy=1. On acceptance: pkt_vld=0, rr pointer=grant+1 mod NUM_OUT_PORTS, state=IDLE. No ack_user is asserted in SEND.
- Throughput and latency: at most one packet per 2 cycles. Latency from vld_user to pkt_vld is 1 cycle when no other stream is pending.
- Credit and address update on grant: credit[i] decrements by 1 and addr[i] increments mod 2^NUM_ADDR_BITS, wrapping 127 to 0.
- credit_upd adds FREESPACE_UPDATE_SIZE to credit[credit_idx], saturating at 2^NUM_ADDR_BITS. Counter width is NUM_ADDR_BITS+1.
- Grant and update to the same stream in the same cycle: net result is credit+FREESPACE_UPDATE_SIZE-1, saturated.
- Credit 0: stream is skipped with no ack, and other streams proceed.
- cfg_wr_en sets cfg_leaf/cfg_port and cfg_valid for cfg_idx. A write to the currently granted stream does not alter the latched packet. cfg_idx or credit_idx >= NUM_OUT_PORTS is ignored.
- Reset during SEND drops the pending packet; pkt_vld falls asynchronously.

Optional Feature:
- Macro: LEAF_OUT_ARB_STATS_EN.
- With the macro: per-stream 32-bit grant counters plus a 32-bit stall counter, which increments each cycle that pkt_vld & ~pkt_rdy. Counters wrap and reset to 0. Added ports: stat_sel (4, in) selects which grant counter stat_grant_cnt (32, out) shows; stat_stall_cnt (32, out).
- Without the macro: no counters and no extra ports.

Decomposition:
- Package leaf_out_arb_pkg holds: state enum (IDLE, SEND), packet field offset localparams derived from the parameters, and a pack function that builds a packet from leaf, port, addr and payload.
- One sub-module, rr_arbiter: NUM_OUT_PORTS request vector plus pointer in; one-hot grant and index out; purely combinational.

Test Plan:
- Single stream: cfg stream0 to leaf 3, port 2; vld_user[0] with 0xDEADBEEF, pkt_rdy=1 -> pkt_vld next cycle, pkt_out={1,5'd3,4'd2,7'd0,32'hDEADBEEF}; ack_user[0] high for exactly 1 cycle.
- Round robin: all 4 streams configured and valid, pkt_rdy=1 -> grant order 0,1,2,3,0; one packet every 2 cycles.
- Credit exhaustion: stream1 alone sends 128 words -> 128th carries addr 127 and credit reaches 0, then stream1 is never acked. One credit_upd for stream1 -> 64 more packets, with the first carrying addr 0.
- Backpressure: pkt_rdy=0 for 5 cycles -> pkt_out stable, ack_user all 0; then pkt_rdy=1 -> accepted, next grant follows.
- Simultaneous: grant and credit_upd to stream2 while its credit is 10 -> credit becomes 73. With credit 128 -> stays 128 (saturated).
- Reset mid-SEND: drop ap_rst_n while pkt_vld=1 -> pkt_vld=0 immediately; after release, credits are 128, addrs 0, cfg_valid cleared.
